// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter and the SRAM controller:
// FSM encodings, counter width and the controller's default busy-cycle counts.
package sram_arb_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // The controller is built with the same numbers, so both sides agree on timing.
  localparam int DEF_WR_CYCLES = 4;
  localparam int DEF_RD_CYCLES = 3;

  function automatic logic [CNT_W-1:0] busy_cycles(input logic we, input int wr, input int rd);
    return we ? CNT_W'(wr) : CNT_W'(rd);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant logic, purely combinational.
// On a tie the port that did not win last time gets the grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the SRAM controller.
// One trigger per transaction, fixed busy time from a down-counter, one-cycle done.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int WR_CYCLES  = DEF_WR_CYCLES,
  parameter int RD_CYCLES  = DEF_RD_CYCLES
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  iReq0,
  input  logic                  iReq1,
  input  logic                  iWe0,
  input  logic                  iWe1,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0] iData0,
  input  logic [DATA_WIDTH-1:0] iData1,
  output logic                  oGnt0,
  output logic                  oGnt1,
  output logic                  oDone0,
  output logic                  oDone1,
  output logic [DATA_WIDTH-1:0] oRdData,
  output logic                  oTrigger,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oAddress,
  output logic [DATA_WIDTH-1:0] oDataOut,
  input  logic [DATA_WIDTH-1:0] iSRAMDataRead
);

  logic [1:0]       rState;
  logic             rOwner;
  logic             rLast;
  logic [CNT_W-1:0] rCnt;
  logic [1:0]       wGnt;
  logic             wSel;

  rr_arb2 u_rr_arb2 (
    .req  ({iReq1, iReq0}),
    .last (rLast),
    .gnt  (wGnt)
  );

  assign wSel = wGnt[1];

  // NOTE: all state below is registered with non-blocking assignments so every
  // branch sees the pre-edge values; the pulse outputs default low each cycle.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rState       <= ST_IDLE;
      rOwner       <= 1'b0;
      rLast        <= 1'b1;
      rCnt         <= '0;
      oGnt0        <= 1'b0;
      oGnt1        <= 1'b0;
      oDone0       <= 1'b0;
      oDone1       <= 1'b0;
      oRdData      <= '0;
      oTrigger     <= 1'b0;
      oWriteEnable <= 1'b0;
      oAddress     <= '0;
      oDataOut     <= '0;
    end else begin
      oTrigger <= 1'b0;
      oDone0   <= 1'b0;
      oDone1   <= 1'b0;
      case (rState)
        ST_IDLE: begin
          if (wGnt != 2'b00) begin
            rOwner       <= wSel;
            rLast        <= wSel;
            oGnt0        <= wGnt[0];
            oGnt1        <= wGnt[1];
            oWriteEnable <= wSel ? iWe1   : iWe0;
            oAddress     <= wSel ? iAddr1 : iAddr0;
            oDataOut     <= wSel ? iData1 : iData0;
            // Trigger is registered here so it is high during the ISSUE cycle.
            oTrigger     <= 1'b1;
            rState       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rCnt   <= busy_cycles(oWriteEnable, WR_CYCLES, RD_CYCLES);
          rState <= ST_WAIT;
        end
        ST_WAIT: begin
          rCnt <= rCnt - 1'b1;
          if (rCnt == CNT_W'(1)) begin
            rState <= ST_DONE;
            if (!oWriteEnable) oRdData <= iSRAMDataRead;
            if (rOwner) oDone1 <= 1'b1;
            else        oDone0 <= 1'b1;
          end
        end
        ST_DONE: begin
          oGnt0  <= 1'b0;
          oGnt1  <= 1'b0;
          rState <= ST_IDLE;
        end
        default: rState <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a randomized
// round-robin run against a transaction-level model of grants, latency and read data.
module tb_sram_port_arbiter;

  logic        Clock;
  logic        Reset_n;
  logic        iReq0, iReq1, iWe0, iWe1;
  logic [7:0]  iAddr0, iAddr1;
  logic [15:0] iData0, iData1, iSRAMDataRead;
  logic        oGnt0, oGnt1, oDone0, oDone1, oTrigger, oWriteEnable;
  logic [15:0] oRdData, oDataOut;
  logic [7:0]  oAddress;

  // Second instance with a longer read sequence.
  logic        p7Req, p7We, z1;
  logic [7:0]  p7Addr, z8;
  logic [15:0] p7Data, p7Rd, z16;
  logic        p7Gnt0, p7Gnt1, p7Done0, p7Done1, p7Trig, p7WeOut;
  logic [15:0] p7RdData, p7DataOut;
  logic [7:0]  p7AddrOut;

  sram_port_arbiter dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .iReq0(iReq0), .iReq1(iReq1), .iWe0(iWe0), .iWe1(iWe1),
    .iAddr0(iAddr0), .iAddr1(iAddr1), .iData0(iData0), .iData1(iData1),
    .oGnt0(oGnt0), .oGnt1(oGnt1), .oDone0(oDone0), .oDone1(oDone1),
    .oRdData(oRdData), .oTrigger(oTrigger), .oWriteEnable(oWriteEnable),
    .oAddress(oAddress), .oDataOut(oDataOut), .iSRAMDataRead(iSRAMDataRead)
  );

  sram_port_arbiter #(.RD_CYCLES(7)) dut7 (
    .Clock(Clock), .Reset_n(Reset_n),
    .iReq0(p7Req), .iReq1(z1), .iWe0(p7We), .iWe1(z1),
    .iAddr0(p7Addr), .iAddr1(z8), .iData0(p7Data), .iData1(z16),
    .oGnt0(p7Gnt0), .oGnt1(p7Gnt1), .oDone0(p7Done0), .oDone1(p7Done1),
    .oRdData(p7RdData), .oTrigger(p7Trig), .oWriteEnable(p7WeOut),
    .oAddress(p7AddrOut), .oDataOut(p7DataOut), .iSRAMDataRead(p7Rd)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int trig_cyc = 0;
  int done_cyc = 0;
  int m_last = 1;
  logic [15:0] m_rd = '0;

  typedef struct {
    bit          pend;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
  } req_t;
  req_t pq[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] outs();
    return {18'd0, oGnt0, oGnt1, oDone0, oDone1, oTrigger, oWriteEnable,
            oAddress, oDataOut, oRdData};
  endfunction

  function automatic int busy(input logic we);
    return we ? 4 : 3;
  endfunction

  task automatic drive_port(input int p, input logic req, input logic we,
                            input logic [7:0] a, input logic [15:0] d);
    if (p == 0) begin iReq0 = req; iWe0 = we; iAddr0 = a; iData0 = d; end
    else        begin iReq1 = req; iWe1 = we; iAddr1 = a; iData1 = d; end
  endtask

  task automatic set_req(input int p, input logic v);
    if (p == 0) iReq0 = v;
    else        iReq1 = v;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    iReq0 = 0; iReq1 = 0; p7Req = 0;
    repeat (2) tick();
    check("reset_outputs", outs(), 64'd0);
    Reset_n = 1'b1;
    m_last = 1;
    m_rd = '0;
  endtask

  task automatic wait_trigger(input int p, input logic we, input logic [7:0] a,
                              input logic [15:0] d, input bit check_gap);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!oTrigger && n < 10);
    trig_cyc = cyc;
    check("trigger_seen", oTrigger, 1);
    check("grant_at_trigger", {oGnt1, oGnt0}, (p == 1) ? 2'b10 : 2'b01);
    check("we_at_trigger", oWriteEnable, we);
    check("addr_at_trigger", oAddress, a);
    check("data_at_trigger", oDataOut, d);
    if (check_gap) check("done_to_trigger", trig_cyc - done_cyc, 2);
  endtask

  task automatic wait_done(input int p, input logic we, input logic [7:0] a,
                           input logic [15:0] d, input logic [15:0] rd);
    int n = 0;
    int trig_cnt = 0;
    bit excl_ok = 1;
    bit hold_ok = 1;
    do begin
      tick();
      n++;
      if (oTrigger) trig_cnt++;
      if (oGnt0 && oGnt1) excl_ok = 0;
      if (oAddress !== a || oDataOut !== d || oWriteEnable !== we ||
          ((p == 1) ? !oGnt1 : !oGnt0)) hold_ok = 0;
    end while (!(oDone0 || oDone1) && n < 40);
    done_cyc = cyc;
    check("done_latency", done_cyc - trig_cyc, busy(we) + 1);
    check("done_owner", {oDone1, oDone0}, (p == 1) ? 2'b10 : 2'b01);
    check("no_retrigger", trig_cnt, 0);
    check("gnt_exclusive", excl_ok, 1);
    check("fields_held", hold_ok, 1);
    if (!we) m_rd = rd;
    check("rd_data", oRdData, m_rd);
  endtask

  initial begin
    int w, n;
    Reset_n = 1'b1;
    iReq0 = 0; iReq1 = 0; iWe0 = 0; iWe1 = 0;
    iAddr0 = 0; iAddr1 = 0; iData0 = 0; iData1 = 0; iSRAMDataRead = 0;
    p7Req = 0; p7We = 0; p7Addr = 0; p7Data = 0; p7Rd = 0;
    z1 = 0; z8 = 0; z16 = 0;
    #2;
    do_reset();

    // Port 0 single write.
    drive_port(0, 1, 1, 8'h12, 16'hBEEF);
    wait_trigger(0, 1, 8'h12, 16'hBEEF, 0);
    wait_done(0, 1, 8'h12, 16'hBEEF, 16'h0);
    set_req(0, 0);
    tick();
    check("done0_one_cycle", {oDone0, oGnt0, oGnt1}, 3'b000);

    // Port 1 read of the same location; data held afterwards.
    iSRAMDataRead = 16'hBEEF;
    drive_port(1, 1, 0, 8'h12, 16'h0);
    wait_trigger(1, 0, 8'h12, 16'h0, 0);
    wait_done(1, 0, 8'h12, 16'h0, 16'hBEEF);
    set_req(1, 0);
    iSRAMDataRead = 16'h0;
    repeat (3) tick();
    check("rd_data_held", oRdData, 16'hBEEF);

    // Both ports held high after reset: grants alternate 0,1,0,1.
    do_reset();
    drive_port(0, 1, 1, 8'h21, 16'h1234);
    drive_port(1, 1, 1, 8'h43, 16'h5678);
    for (int i = 0; i < 4; i++) begin
      w = i % 2;
      wait_trigger(w, 1, (w == 0) ? 8'h21 : 8'h43, (w == 0) ? 16'h1234 : 16'h5678, i > 0);
      wait_done(w, 1, (w == 0) ? 8'h21 : 8'h43, (w == 0) ? 16'h1234 : 16'h5678, 16'h0);
    end
    set_req(0, 0);
    set_req(1, 0);
    tick();

    // Owner address changes mid-WAIT; port 1 arrives mid-WAIT.
    drive_port(0, 1, 1, 8'h12, 16'h1111);
    wait_trigger(0, 1, 8'h12, 16'h1111, 0);
    tick();
    iAddr0 = 8'h34;
    drive_port(1, 1, 0, 8'h56, 16'h0);
    iSRAMDataRead = 16'hC0DE;
    wait_done(0, 1, 8'h12, 16'h1111, 16'h0);
    set_req(0, 0);
    wait_trigger(1, 0, 8'h56, 16'h0, 1);
    wait_done(1, 0, 8'h56, 16'h0, 16'hC0DE);
    set_req(1, 0);
    tick();

    // Asynchronous reset in the second WAIT cycle of a write.
    drive_port(0, 1, 1, 8'h77, 16'hAAAA);
    wait_trigger(0, 1, 8'h77, 16'hAAAA, 0);
    tick();
    tick();
    #2;
    Reset_n = 1'b0;
    #1;
    check("reset_async_outputs", outs(), 64'd0);
    drive_port(0, 1, 0, 8'h01, 16'h0);
    drive_port(1, 1, 1, 8'h02, 16'h9999);
    iSRAMDataRead = 16'h4242;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (outs() != 64'd0) n++;
    end
    check("reset_held_quiet", n, 0);
    Reset_n = 1'b1;
    m_last = 1;
    m_rd = '0;
    wait_trigger(0, 0, 8'h01, 16'h0, 0);
    wait_done(0, 0, 8'h01, 16'h0, 16'h4242);
    set_req(0, 0);
    wait_trigger(1, 1, 8'h02, 16'h9999, 1);
    wait_done(1, 1, 8'h02, 16'h9999, 16'h0);
    set_req(1, 0);
    tick();

    // Randomized traffic against the transaction-level model.
    do_reset();
    pq[0].pend = 0;
    pq[1].pend = 0;
    for (int it = 0; it < 24; it++) begin
      logic [15:0] rdv;
      for (int p = 0; p < 2; p++) begin
        if (!pq[p].pend && ($urandom_range(0, 1) == 1 || (p == 1 && !pq[0].pend))) begin
          pq[p].pend = 1;
          pq[p].we   = 1'($urandom_range(0, 1));
          pq[p].addr = 8'($urandom);
          pq[p].data = 16'($urandom);
          drive_port(p, 1, pq[p].we, pq[p].addr, pq[p].data);
        end
      end
      if (pq[0].pend && pq[1].pend) w = 1 - m_last;
      else                          w = pq[1].pend ? 1 : 0;
      rdv = 16'($urandom);
      iSRAMDataRead = rdv;
      wait_trigger(w, pq[w].we, pq[w].addr, pq[w].data, it > 0);
      wait_done(w, pq[w].we, pq[w].addr, pq[w].data, rdv);
      set_req(w, 0);
      pq[w].pend = 0;
      m_last = w;
    end
    set_req(0, 0);
    set_req(1, 0);
    repeat (4) tick();

    // Longer read sequence: data sampled only at the final WAIT edge.
    p7We = 0; p7Addr = 8'h9A; p7Data = 16'h0; p7Req = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!p7Trig && n < 10);
    check("p7_trigger", {p7Trig, p7WeOut, p7AddrOut, p7DataOut}, {1'b1, 1'b0, 8'h9A, 16'h0});
    trig_cyc = cyc;
    p7Rd = 16'h1111;
    n = 0;
    do begin
      tick();
      n++;
      if (cyc - trig_cyc < 7)       p7Rd = 16'h1111;
      else if (cyc - trig_cyc == 7) p7Rd = 16'h2222;
      else                          p7Rd = 16'h3333;
    end while (!p7Done0 && n < 20);
    p7Req = 0;
    check("p7_done_latency", cyc - trig_cyc, 8);
    check("p7_rd_capture", p7RdData, 16'h2222);
    check("p7_port1_idle", {p7Gnt1, p7Done1, p7Gnt0}, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
